alu_bist_ctrl: RTL

- Synthesizable built-in self-test controller; the initiator/checker side of the 4-bit ALU interface (a, b, sel -> result).
- On start, drives every (a, b, sel) combination into the ALU, samples alu_result after a settle delay, and compares it against an internal golden model.
- Reports done, pass, a saturating error count and, optionally, the first failing vector.
- Sits beside the ALU instance; the ALU operand/select inputs are muxed to this block in test mode.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_bist_ctrl_if.sv | 28 ++
 rtl/alu_ref_model.sv | 35 +++
 rtl/alu_bist_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default widths and the BIST
// controller state encoding.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_SEL_W  = 3;
  localparam int ALU_RES_W  = 2 * ALU_DATA_W;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_SEL_W-1:0] ALU_SHL = 3'b010;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 3'b011;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 3'b100;
  localparam logic [ALU_SEL_W-1:0] ALU_NOT = 3'b101;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 3'b110;
  localparam logic [ALU_SEL_W-1:0] ALU_SHR = 3'b111;

  typedef logic [2:0] bist_state_t;

  localparam bist_state_t ST_IDLE  = 3'd0;
  localparam bist_state_t ST_DRIVE = 3'd1;
  localparam bist_state_t ST_WAIT  = 3'd2;
  localparam bist_state_t ST_CHECK = 3'd3;
  localparam bist_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/alu_bist_ctrl_if.sv
// ALU operand/result bus between the BIST controller (master) and the
// ALU under test (slave).
interface alu_bist_ctrl_if #(
  parameter int DATA_W = alu_pkg::ALU_DATA_W,
  parameter int SEL_W  = alu_pkg::ALU_SEL_W,
  parameter int RES_W  = alu_pkg::ALU_RES_W
) ();

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [RES_W-1:0]  alu_result;

  modport master (
    output alu_a,
    output alu_b,
    output alu_sel,
    input  alu_result
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_sel,
    output alu_result
  );

endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU; operands are zero-extended to the
// result width before the operation.
module alu_ref_model #(
  parameter int DATA_W = alu_pkg::ALU_DATA_W,
  parameter int SEL_W  = alu_pkg::ALU_SEL_W,
  parameter int RES_W  = alu_pkg::ALU_RES_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [RES_W-1:0]  expected
);
  import alu_pkg::*;

  logic [RES_W-1:0] a_x;
  logic [RES_W-1:0] b_x;

  assign a_x = {{(RES_W-DATA_W){1'b0}}, a};
  assign b_x = {{(RES_W-DATA_W){1'b0}}, b};

  always_comb begin
    case (sel)
      ALU_ADD: expected = a_x + b_x;
      ALU_SUB: expected = a_x - b_x;
      ALU_SHL: expected = a_x << b;
      ALU_AND: expected = a_x & b_x;
      ALU_OR:  expected = a_x | b_x;
      ALU_NOT: expected = {{(RES_W-DATA_W){1'b0}}, ~a};
      ALU_XOR: expected = a_x ^ b_x;
      ALU_SHR: expected = a_x >> b;
      default: expected = {RES_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// Exhaustive ALU self-test controller. Optional first-failure capture is
// built only when ALU_BIST_FAIL_LOG_EN is defined.
module alu_bist_ctrl #(
  parameter int DATA_W        = 4,
  parameter int SEL_W         = 3,
  parameter int RES_W         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  alu_bist_ctrl_if.master     alu,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic                fail_valid,
  output logic [DATA_W-1:0]   fail_a,
  output logic [DATA_W-1:0]   fail_b,
  output logic [SEL_W-1:0]    fail_sel,
  output logic [RES_W-1:0]    fail_got
);
  import alu_pkg::*;

  localparam int IDX_W = 2 * DATA_W + SEL_W;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  bist_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic               start_ok_s;
  logic               mismatch_s;
  logic [RES_W-1:0]   golden_s;

  // The golden value is derived from the vector index, not from the driven operands.
  alu_ref_model #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W),
    .RES_W  (RES_W)
  ) u_ref (
    .a        (idx_q[IDX_W-1 -: DATA_W]),
    .b        (idx_q[SEL_W +: DATA_W]),
    .sel      (idx_q[SEL_W-1:0]),
    .expected (golden_s)
  );

  assign start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch_s = (alu.alu_result != golden_s);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          state_d = ST_DRIVE;
          idx_d   = {IDX_W{1'b0}};
          err_d   = {ERR_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_DRIVE: begin
        alu_a_d   = idx_q[IDX_W-1 -: DATA_W];
        alu_b_d   = idx_q[SEL_W +: DATA_W];
        alu_sel_d = idx_q[SEL_W-1:0];
        settle_d  = {CNT_W{1'b0}};
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch_s && (err_q != {ERR_W{1'b1}})) begin
          err_d = err_q + ERR_W'(1);
        end else begin
          err_d = err_q;
        end
        if (idx_q == {IDX_W{1'b1}}) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == {ERR_W{1'b0}});
  end

  // Controller state and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= {IDX_W{1'b0}};
      settle_q  <= {CNT_W{1'b0}};
      alu_a_q   <= {DATA_W{1'b0}};
      alu_b_q   <= {DATA_W{1'b0}};
      alu_sel_q <= {SEL_W{1'b0}};
      err_q     <= {ERR_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign alu.alu_a   = alu_a_q;
  assign alu.alu_b   = alu_b_q;
  assign alu.alu_sel = alu_sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;

`ifdef ALU_BIST_FAIL_LOG_EN
  logic               fail_valid_q, fail_valid_d;
  logic [DATA_W-1:0]  fail_a_q, fail_a_d;
  logic [DATA_W-1:0]  fail_b_q, fail_b_d;
  logic [SEL_W-1:0]   fail_sel_q, fail_sel_d;
  logic [RES_W-1:0]   fail_got_q, fail_got_d;

  // Only the first mismatch of a run is logged; an accepted start clears it.
  always_comb begin
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_sel_d   = fail_sel_q;
    fail_got_d   = fail_got_q;
    if (start_ok_s) begin
      fail_valid_d = 1'b0;
      fail_a_d     = {DATA_W{1'b0}};
      fail_b_d     = {DATA_W{1'b0}};
      fail_sel_d   = {SEL_W{1'b0}};
      fail_got_d   = {RES_W{1'b0}};
    end else if ((state_q == ST_CHECK) && mismatch_s && !fail_valid_q) begin
      fail_valid_d = 1'b1;
      fail_a_d     = alu_a_q;
      fail_b_d     = alu_b_q;
      fail_sel_d   = alu_sel_q;
      fail_got_d   = alu.alu_result;
    end else begin
      fail_valid_d = fail_valid_q;
    end
  end

  // First-failure capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= {DATA_W{1'b0}};
      fail_b_q     <= {DATA_W{1'b0}};
      fail_sel_q   <= {SEL_W{1'b0}};
      fail_got_q   <= {RES_W{1'b0}};
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_sel_q   <= fail_sel_d;
      fail_got_q   <= fail_got_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_sel   = fail_sel_q;
  assign fail_got   = fail_got_q;
`else
  assign fail_valid = 1'b0;
  assign fail_a     = {DATA_W{1'b0}};
  assign fail_b     = {DATA_W{1'b0}};
  assign fail_sel   = {SEL_W{1'b0}};
  assign fail_got   = {RES_W{1'b0}};
`endif

endmodule
